// File: rtl/axistream_pipe_fifo.sv
// AXI-stream pipeline FIFO: a register-array circular buffer of any depth that breaks
// every src-to-dest combinational path and reports occupancy and held complete packets.
module axistream_pipe_fifo #(
    parameter int DATA_WIDTH  = 8,
    parameter int USER_WIDTH  = 1,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          src_tvalid,
    output logic                          src_tready,
    input  logic [DATA_WIDTH-1:0]         src_tdata,
    input  logic [USER_WIDTH-1:0]         src_tuser,
    input  logic                          src_tlast,
    output logic                          dest_tvalid,
    input  logic                          dest_tready,
    output logic [DATA_WIDTH-1:0]         dest_tdata,
    output logic [USER_WIDTH-1:0]         dest_tuser,
    output logic                          dest_tlast,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic                          almost_full,
    output logic [$clog2(DEPTH+1)-1:0]    pkt_count
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int EW = DATA_WIDTH + USER_WIDTH + 1;
    localparam logic [PW-1:0] LAST_PTR  = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr  = '0;
    logic [PW-1:0] rd_ptr  = '0;
    logic [CW-1:0] count_q = '0;
    logic [CW-1:0] pkt_q   = '0;

    logic          wr_en;
    logic          rd_en;
    logic [EW-1:0] head;
    logic          head_last;
    logic          pkt_inc;
    logic          pkt_dec;

    // Flags depend only on registered occupancy, so ready never sees dest_tready.
    assign src_tready  = !rst && (count_q != FULL_CNT);
    assign dest_tvalid = !rst && (count_q != '0);
    assign almost_full = !rst && (count_q >= AFULL_CNT);

    assign wr_en     = src_tvalid && src_tready;
    assign rd_en     = dest_tvalid && dest_tready;
    assign head      = mem[rd_ptr];
    assign head_last = head[EW-1];
    assign pkt_inc   = wr_en && src_tlast;
    assign pkt_dec   = rd_en && head_last;

    assign dest_tdata = head[DATA_WIDTH-1:0];
    assign dest_tuser = head[DATA_WIDTH +: USER_WIDTH];
    assign dest_tlast = head_last && dest_tvalid;
    assign count      = count_q;
    assign pkt_count  = pkt_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {src_tlast, src_tuser, src_tdata};
        end
    end

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            pkt_q   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_q <= pkt_q + 1'b1;
                2'b01:   pkt_q <= pkt_q - 1'b1;
                default: pkt_q <= pkt_q;
            endcase
        end
    end
endmodule

// File: doc/axistream_pipe_fifo.md
Name: axistream_pipe_fifo

Overview:
- Parametrised successor to the team's fixed 3-deep AXI-stream timing-break buffer.
- Adds configurable depth, sideband tuser, occupancy and almost-full status, and a complete-packet counter for downstream packet-mode consumers.
- Sits inline on any AXI-stream link where src-to-dest combinational paths must be broken.
- Register-array circular buffer. Supports non-power-of-two depths.

Parameters:
- DATA_WIDTH, 8, tdata width in bits.
- USER_WIDTH, 1, tuser width in bits (minimum 1).
- DEPTH, 4, buffer entries. Legal range 2..256; any integer in range is allowed.
- AFULL_LEVEL, DEPTH-1, almost_full asserts when occupancy >= this value (legal range 1..DEPTH).

Ports:
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- src_tvalid  input  1  upstream beat valid
- src_tready  output  1  buffer can accept a beat
- src_tdata  input  DATA_WIDTH  upstream data
- src_tuser  input  USER_WIDTH  upstream sideband
- src_tlast  input  1  upstream end of packet
- dest_tvalid  output  1  beat available
- dest_tready  input  1  downstream accepts
- dest_tdata  output  DATA_WIDTH  head data
- dest_tuser  output  USER_WIDTH  head sideband
- dest_tlast  output  1  head end of packet, gated by dest_tvalid
- count  output  clog2(DEPTH+1)  beats held
- almost_full  output  1  count >= AFULL_LEVEL
- pkt_count  output  clog2(DEPTH+1)  complete packets held (tlast beats in buffer)

Behaviour:
- Handshakes:
  - Write occurs when src_tvalid && src_tready.
  - Read occurs when dest_tvalid && dest_tready.
- Storage and pointers:
  - Each entry stores {tlast, tuser, tdata}.
  - wr_ptr and rd_ptr wrap from DEPTH-1 to 0. Explicit compare; no power-of-two masking.
- Output flags:
  - src_tready = !rst && (count != DEPTH).
  - dest_tvalid = !rst && (count != 0).
  - dest_tdata, dest_tuser and dest_tlast are read from the entry at rd_ptr.
- Path rules:
  - No combinational path dest_tready -> src_tready.
  - No combinational path src_tvalid/src_tdata -> dest_*.
  - Consequence: when full, a write is refused even if a read occurs in the same cycle.
- Latency: a beat written at edge N is presented on dest from edge N (visible in cycle N+1). Minimum latency 1 cycle. Full-rate throughput 1 beat/cycle when count is between 1 and DEPTH-1.
- count update:
  - write only: +1.
  - read only: -1.
  - both, or neither: unchanged.
  - count never exceeds DEPTH and never goes below 0.
  - Read with count==0 is impossible, since dest_tvalid is low. The bench asserts this never happens.
- pkt_count update:
  - +1 on a write with src_tlast=1.
  - -1 on a read with the head entry's tlast=1.
  - Simultaneous +1 and -1: unchanged.
  - Invariant: pkt_count <= count.
- almost_full is combinational from count.
- Reset (synchronous, takes effect at the edge where rst=1):
  - count, pkt_count, wr_ptr, rd_ptr all go to 0.
  - Storage contents are not cleared (don't-care).
  - While rst=1: src_tready=0, dest_tvalid=0, dest_tlast=0, almost_full=0.
  - Handshakes in the reset cycle are ignored, and in-flight data is discarded.
- Initial values: counters and pointers also initialise to 0 for simulation, so outputs are defined before the first rst.
- Upstream tvalid/tdata behaviour is not required to be AXI-compliant. The block still never loses or duplicates an accepted beat.

Test Plan:
- Fill/drain, DEPTH=4: hold dest_tready=0 and send 0x11..0x14, then 0x15 -> src_tready drops after the 4th accept, count=4, almost_full=1 from count=3. Release dest_tready -> 0x11..0x14 emerge in order; 0x15 is accepted once count=3.
- Full-rate streaming: src_tvalid and dest_tready held 1, 100 incrementing beats -> output equals input, count stays at 1, no stalls after the first cycle.
- Full plus simultaneous read, DEPTH=4 full, dest_tready=1 and src_tvalid=1 in the same cycle -> exactly one read and no write that cycle, count 4->3; the write is accepted the next cycle.
- Non-power-of-two wrap, DEPTH=3, random valid/ready over 1000 beats -> scoreboard order is preserved, pointers wrap 2->0, count never exceeds 3.
- Packet counting: send 3 packets of lengths 1, 2 and 1 with dest_tready=0 -> pkt_count=3, count=4. Drain -> pkt_count steps 3,2,1,0 after each tlast read; dest_tuser matches per beat.
- Reset mid-operation: count=2, assert rst for 1 cycle with src_tvalid=1 -> next cycle count=0, pkt_count=0, dest_tvalid=0, and the beat offered during rst does not appear at dest.
